// File: rtl/simt_pkg.sv
// Shared types and constants for the SIMT branch-resolution slice.
package simt_pkg;

  localparam int NUM_WARPS = 8;
  localparam int WARP_W    = 3;
  localparam int THREADS   = 8;

  localparam logic [1:0] SYNC = 2'b00;
  localparam logic [1:0] DIV  = 2'b01;
  localparam logic [1:0] CALL = 2'b10;

  typedef struct packed {
    logic [WARP_W-1:0]  warp;
    logic               dots;
    logic [THREADS-1:0] active;
    logic [THREADS-1:0] cond;
    logic [31:0]        target;
  } br_entry_t;

endpackage

// File: rtl/simt_br_fifo.sv
// Resolved-branch outcome FIFO; full/empty use an extra pointer MSB.
module simt_br_fifo
  import simt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  br_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output br_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  br_entry_t       mem_q [DEPTH];
  br_entry_t       mem_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/simt_branch_resolve_chk.sv
// Protocol and counter-range checks for simt_branch_resolve.
module simt_branch_resolve_chk #(
  parameter int NW = 8
) (
  input logic          clk,
  input logic          rst_n,
  input logic          alu_valid,
  input logic          alu_ready,
  input logic [NW-1:0] cnt_ovf,
  input logic [NW-1:0] cnt_udf
);

  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_valid && !alu_ready));

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_ovf == '0);

  a_no_udf: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_udf == '0);

endmodule

// File: rtl/simt_branch_resolve.sv
// WB-side branch resolution: outcome FIFO, SIMT update/redirect, per-warp pending counters.
// Optional same-cycle bypass when empty: define SIMT_BR_BYPASS_EN.
module simt_branch_resolve
  import simt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PEND_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ALU_Br_Valid,
  input  logic [WARP_W-1:0]    ALU_Br_WarpID,
  input  logic                 ALU_Br_DotS,
  input  logic [THREADS-1:0]   ALU_Br_Active_Mask,
  input  logic [THREADS-1:0]   ALU_Br_Cond_Mask,
  input  logic [31:0]          ALU_Br_Target,
  output logic                 ALU_Br_Ready,
  input  logic                 WB_Hold,
  output logic                 WB_Update_SIMT,
  output logic [WARP_W-1:0]    WarpID_from_WB,
  output logic [THREADS-1:0]   WB_AM_SIMT,
  output logic                 BR_Redirect_Valid,
  output logic [WARP_W-1:0]    BR_Redirect_WarpID,
  output logic [31:0]          BR_Redirect_PC,
  output logic [THREADS-1:0]   BR_Redirect_Mask,
  input  logic [NUM_WARPS-1:0] ID_Branch_Issue,
  output logic [NUM_WARPS-1:0] BR_Pending
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  br_entry_t            alu_ent;
  br_entry_t            head;
  br_entry_t            sel;
  logic                 full, empty;
  logic                 push, pop, drain, bypass;
  logic [THREADS-1:0]   taken, untaken;
  logic                 run_q, run_d;
  logic [PEND_W-1:0]    cnt_q [NUM_WARPS];
  logic [PEND_W-1:0]    cnt_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] dec_vec, cnt_ovf, cnt_udf;

  assign alu_ent = '{warp:   ALU_Br_WarpID,
                     dots:   ALU_Br_DotS,
                     active: ALU_Br_Active_Mask,
                     cond:   ALU_Br_Cond_Mask,
                     target: ALU_Br_Target};

  // run_q keeps Ready low while in reset so every output reads 0 there.
  assign run_d        = 1'b1;
  assign ALU_Br_Ready = run_q && !full;

`ifdef SIMT_BR_BYPASS_EN
  assign bypass = run_q && empty && ALU_Br_Valid && !WB_Hold;
`else
  assign bypass = 1'b0;
`endif

  assign push  = ALU_Br_Valid && ALU_Br_Ready && !bypass;
  assign pop   = !empty && !WB_Hold;
  assign drain = pop || bypass;
  assign sel   = bypass ? alu_ent : head;

  simt_br_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (alu_ent),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    taken              = sel.active & sel.cond;
    untaken            = sel.active & ~sel.cond;
    WB_Update_SIMT     = 1'b0;
    WarpID_from_WB     = '0;
    WB_AM_SIMT         = '0;
    BR_Redirect_Valid  = 1'b0;
    BR_Redirect_WarpID = '0;
    BR_Redirect_PC     = '0;
    BR_Redirect_Mask   = '0;
    if (drain) begin
      WB_Update_SIMT = 1'b1;
      WarpID_from_WB = sel.warp;
      // Only a genuinely split .s branch hands a not-taken mask to the stack.
      WB_AM_SIMT     = (sel.dots && (taken != 8'h00)) ? untaken : 8'h00;
      if (taken != 8'h00) begin
        BR_Redirect_Valid  = 1'b1;
        BR_Redirect_WarpID = sel.warp;
        BR_Redirect_PC     = sel.target;
        BR_Redirect_Mask   = taken;
      end else begin
        BR_Redirect_Valid  = 1'b0;
      end
    end else begin
      WB_Update_SIMT = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      dec_vec[i] = drain && (sel.warp == WARP_W'(i));
      cnt_d[i]   = cnt_q[i];
      cnt_ovf[i] = 1'b0;
      cnt_udf[i] = 1'b0;
      // Out-of-range requests saturate and are flagged to the checker.
      if (ID_Branch_Issue[i] && !dec_vec[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cnt_ovf[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + PEND_W'(1);
        end
      end else if (!ID_Branch_Issue[i] && dec_vec[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_udf[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - PEND_W'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      BR_Pending[i] = (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  simt_branch_resolve_chk #(.NW(NUM_WARPS)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (ALU_Br_Valid),
    .alu_ready (ALU_Br_Ready),
    .cnt_ovf   (cnt_ovf),
    .cnt_udf   (cnt_udf)
  );

endmodule
